// File: rtl/spi_tx_arb_pkg.sv
// Shared definitions for the SPI TX arbiter: FSM encoding and the width helpers
// used to size the round-robin pointer and the timeout counter.
package spi_tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Index width for a requester vector; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

  // The counter only has to reach (timeout - 1) of the larger timeout.
  function automatic int cnt_width(input int ack_to, input int gap_to);
    int m;
    m = (ack_to > gap_to) ? ack_to : gap_to;
    return (m < 2) ? 1 : clog2(m);
  endfunction

endpackage

// File: rtl/spi_tx_arb_rr_pick.sv
// Combinational round-robin picker: returns the first requester strictly after
// the pointer (wrapping), as a one-hot vector plus a valid flag.
module spi_tx_arb_rr_pick
  import spi_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]            req,
  input  logic [ptr_width(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]            pick,
  output logic                          valid
);

  localparam int IW = ptr_width(NUM_REQ);

  logic [IW-1:0] sel;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    sel   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sel = IW'((int'(ptr) + k) % NUM_REQ);
      if (!valid && req[sel]) begin
        pick[sel] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_tx_arb.sv
// Burst-locked round-robin arbiter sharing one spi_slave TX port among NUM_REQ
// requesters. Handshake: the owner holds req_i/last_i/data_i until ack_o pulses.
module spi_tx_arb
  import spi_tx_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int BUS_DATA_WIDTH = 8,
  parameter int ACK_TIMEOUT    = 1024,
  parameter int GAP_TIMEOUT    = 256
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_i,
  input  logic [NUM_REQ-1:0]                last_i,
  input  logic [NUM_REQ*BUS_DATA_WIDTH-1:0] data_i,
  output logic [NUM_REQ-1:0]                ack_o,
  output logic [NUM_REQ-1:0]                abort_o,
  output logic [NUM_REQ-1:0]                grant_o,
  input  logic                              frame_end_i,
  output logic                              tx_req_o,
  output logic [BUS_DATA_WIDTH-1:0]         tx_data_o,
  input  logic                              tx_ack_i,
  output logic                              busy_o,
  output logic [1:0]                        dbg_state_o
);

  localparam int IW = ptr_width(NUM_REQ);
  localparam int CW = cnt_width(ACK_TIMEOUT, GAP_TIMEOUT);
  localparam logic [CW-1:0] ACK_LIM = CW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] GAP_LIM = CW'((GAP_TIMEOUT > 0) ? GAP_TIMEOUT - 1 : 0);

  state_t              state;
  logic [NUM_REQ-1:0]  grant;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       gidx;
  logic                tx_req;
  logic [CW-1:0]       cnt;

  logic [NUM_REQ-1:0]  pick;
  logic                pick_valid;
  logic                owner_req;
  logic                owner_last;
  logic                word_ack;
  logic                ack_to;
  logic                gap_to;
  logic                abort_cond;

  spi_tx_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req_i),
    .ptr   (ptr),
    .pick  (pick),
    .valid (pick_valid)
  );

  always_comb begin
    gidx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) gidx = IW'(k);
    end
  end

  always_comb begin
    tx_data_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) tx_data_o = data_i[k*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
    end
  end

  assign owner_req  = |(req_i & grant);
  assign owner_last = |(last_i & grant);
  assign word_ack   = (state == ST_XFER) && tx_req && tx_ack_i;
  assign ack_to     = (ACK_TIMEOUT != 0) && (state == ST_XFER) && (cnt == ACK_LIM);
  assign gap_to     = (GAP_TIMEOUT != 0) && (state == ST_HOLD) && (cnt == GAP_LIM);

  // An accepted last word closes the burst cleanly even if the frame ends with it.
  assign abort_cond = (state != ST_IDLE) && !(word_ack && owner_last) &&
                      (frame_end_i || (!word_ack && (ack_to || gap_to)));

  assign ack_o       = word_ack   ? grant : '0;
  assign abort_o     = abort_cond ? grant : '0;
  assign grant_o     = grant;
  assign tx_req_o    = tx_req;
  assign busy_o      = (state != ST_IDLE);
  assign dbg_state_o = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      grant  <= '0;
      ptr    <= IW'(NUM_REQ - 1);
      tx_req <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (pick_valid) begin
            grant  <= pick;
            tx_req <= 1'b1;
            state  <= ST_XFER;
          end
        end
        ST_XFER, ST_HOLD: begin
          cnt <= cnt + 1'b1;
          if (word_ack && (owner_last || frame_end_i)) begin
            state  <= ST_IDLE;
            grant  <= '0;
            tx_req <= 1'b0;
            cnt    <= '0;
            ptr    <= gidx;
          end else if (word_ack) begin
            // spi_slave needs a low cycle on wr_en between words.
            tx_req <= 1'b0;
            cnt    <= '0;
          end else if (abort_cond) begin
            state  <= ST_IDLE;
            grant  <= '0;
            tx_req <= 1'b0;
            cnt    <= '0;
            ptr    <= gidx;
          end else if (state == ST_HOLD) begin
            if (owner_req) begin
              state  <= ST_XFER;
              tx_req <= 1'b1;
              cnt    <= '0;
            end
          end else if (tx_req) begin
            if (!owner_req) begin
              state  <= ST_HOLD;
              tx_req <= 1'b0;
              cnt    <= '0;
            end
          end else if (owner_req) begin
            tx_req <= 1'b1;
          end else begin
            state <= ST_HOLD;
            cnt   <= '0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          grant  <= '0;
          tx_req <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_arb.sv
// Directed bench for spi_tx_arb: stimulus pushes expected ack/abort events into a
// queue that a negedge monitor pops whenever the DUT pulses ack_o or abort_o.
module tb_spi_tx_arb;
  import spi_tx_arb_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  req_i;
  logic [3:0]  last_i;
  logic [31:0] data_i;
  logic [3:0]  ack_o;
  logic [3:0]  abort_o;
  logic [3:0]  grant_o;
  logic        frame_end_i;
  logic        tx_req_o;
  logic [7:0]  tx_data_o;
  logic        tx_ack_i;
  logic        busy_o;
  logic [1:0]  dbg_state_o;

  // Event word: {abort_o, ack_o, tx_data_o}
  logic [15:0] exp_q[$];
  int n_cmp;
  int n_bad;

  spi_tx_arb #(
    .NUM_REQ(4), .BUS_DATA_WIDTH(8), .ACK_TIMEOUT(16), .GAP_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .last_i(last_i), .data_i(data_i),
    .ack_o(ack_o), .abort_o(abort_o), .grant_o(grant_o), .frame_end_i(frame_end_i),
    .tx_req_o(tx_req_o), .tx_data_o(tx_data_o), .tx_ack_i(tx_ack_i),
    .busy_o(busy_o), .dbg_state_o(dbg_state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [15:0] act;
    logic [15:0] exp_v;
    if (!rst && ((|ack_o) || (|abort_o))) begin
      act = {abort_o, ack_o, tx_data_o};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL event_unexpected: got %h expected none", act);
      end else begin
        exp_v = exp_q.pop_front();
        if (act !== exp_v) begin
          n_bad++;
          $display("FAIL event: got %h expected %h", act, exp_v);
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic set_data(input int k, input logic [7:0] d);
    data_i[k*8 +: 8] = d;
  endtask

  task automatic ack_word(input int k, input logic [7:0] d);
    check("tx_req_before_ack", 32'(tx_req_o), 32'd1);
    exp_q.push_back({4'b0000, 4'(1 << k), d});
    tx_ack_i = 1'b1;
    tick();
    tx_ack_i = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; req_i = '0; last_i = '0; data_i = '0; frame_end_i = 1'b0; tx_ack_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", 32'(grant_o), 32'h0);
    check("rst_tx_req", 32'(tx_req_o), 32'h0);
    check("rst_tx_data", 32'(tx_data_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_ack_abort", 32'({ack_o, abort_o}), 32'h0);
    check("rst_state", 32'(dbg_state_o), 32'(ST_IDLE));
    rst = 1'b0;
    tick();

    // Fairness: all request, 1-word bursts, order 0,1,2,3,0
    for (int k = 0; k < 4; k++) set_data(k, 8'(8'h10 + k));
    req_i = 4'hF; last_i = 4'hF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("fair_grant", 32'(grant_o), 32'(1 << (i % 4)));
      check("fair_data", 32'(tx_data_o), 32'(8'h10 + (i % 4)));
      ack_word(i % 4, 8'(8'h10 + (i % 4)));
    end
    req_i = '0; last_i = '0;

    // Single word from requester 0
    set_data(0, 8'hA5); req_i = 4'b0001; last_i = 4'b0001;
    tick();
    check("single_grant", 32'(grant_o), 32'h1);
    check("single_data", 32'(tx_data_o), 32'hA5);
    check("single_busy", 32'(busy_o), 32'h1);
    ack_word(0, 8'hA5);
    req_i = '0; last_i = '0;
    check("single_idle_req", 32'(tx_req_o), 32'h0);
    check("single_idle_grant", 32'(grant_o), 32'h0);
    check("single_idle_busy", 32'(busy_o), 32'h0);

    // Burst lock: requester 1 sends 3 words while 2 waits
    set_data(1, 8'h31); set_data(2, 8'h42); req_i = 4'b0110; last_i = 4'b0100;
    tick();
    check("lock_grant1", 32'(grant_o), 32'h2);
    ack_word(1, 8'h31);
    check("lock_recovery_req", 32'(tx_req_o), 32'h0);
    check("lock_recovery_grant", 32'(grant_o), 32'h2);
    set_data(1, 8'h32);
    tick();
    check("lock_grant2", 32'(grant_o), 32'h2);
    ack_word(1, 8'h32);
    set_data(1, 8'h33); last_i = 4'b0110;
    tick();
    check("lock_grant3", 32'(grant_o), 32'h2);
    ack_word(1, 8'h33);
    req_i = 4'b0100;
    check("lock_released", 32'(grant_o), 32'h0);
    tick();
    check("lock_next_owner", 32'(grant_o), 32'h4);
    ack_word(2, 8'h42);
    req_i = '0; last_i = '0;

    // Gap shorter than GAP_TIMEOUT: HOLD, then resume
    set_data(1, 8'h51); req_i = 4'b0010;
    tick();
    check("gap_grant", 32'(grant_o), 32'h2);
    ack_word(1, 8'h51);
    req_i = '0;
    repeat (4) tick();
    check("gap_hold_state", 32'(dbg_state_o), 32'(ST_HOLD));
    check("gap_hold_grant", 32'(grant_o), 32'h2);
    check("gap_hold_req", 32'(tx_req_o), 32'h0);
    set_data(1, 8'h52); req_i = 4'b0010; last_i = 4'b0010;
    tick();
    check("gap_resume_req", 32'(tx_req_o), 32'h1);
    ack_word(1, 8'h52);
    req_i = '0; last_i = '0;

    // Gap timeout: abort on the 8th HOLD cycle
    set_data(1, 8'h61); req_i = 4'b0010;
    tick();
    check("gapto_grant", 32'(grant_o), 32'h2);
    ack_word(1, 8'h61);
    req_i = '0;
    tick();
    exp_q.push_back({4'b0010, 4'b0000, 8'h61});
    repeat (6) tick();
    check("gapto_early", 32'(abort_o), 32'h0);
    tick();
    check("gapto_abort", 32'(abort_o), 32'h2);
    tick();
    check("gapto_idle", 32'({busy_o, grant_o}), 32'h0);

    // Ack timeout: 16 cycles of tx_req without tx_ack
    set_data(3, 8'hC3); req_i = 4'b1000;
    tick();
    check("ackto_grant", 32'(grant_o), 32'h8);
    exp_q.push_back({4'b1000, 4'b0000, 8'hC3});
    repeat (14) tick();
    check("ackto_early", 32'(abort_o), 32'h0);
    tick();
    check("ackto_abort", 32'(abort_o), 32'h8);
    req_i = '0;
    tick();
    check("ackto_idle", 32'(busy_o), 32'h0);

    // Owner drops req in XFER -> HOLD; frame end in HOLD aborts
    set_data(2, 8'h71); req_i = 4'b0100;
    tick();
    check("drop_grant", 32'(grant_o), 32'h4);
    req_i = '0;
    tick();
    check("drop_hold_state", 32'(dbg_state_o), 32'(ST_HOLD));
    check("drop_hold_req", 32'(tx_req_o), 32'h0);
    frame_end_i = 1'b1;
    exp_q.push_back({4'b0100, 4'b0000, 8'h71});
    #1;
    check("hold_fe_abort", 32'(abort_o), 32'h4);
    tick();
    frame_end_i = 1'b0;
    check("hold_fe_idle", 32'({busy_o, grant_o}), 32'h0);

    // Frame end mid-burst in XFER
    set_data(0, 8'h81); req_i = 4'b0001;
    tick();
    check("fe_grant", 32'(grant_o), 32'h1);
    frame_end_i = 1'b1;
    exp_q.push_back({4'b0001, 4'b0000, 8'h81});
    #1;
    check("fe_abort", 32'(abort_o), 32'h1);
    tick();
    frame_end_i = 1'b0; req_i = '0;
    check("fe_tx_req", 32'(tx_req_o), 32'h0);
    check("fe_grant_clr", 32'(grant_o), 32'h0);

    // Frame end with ack on last word: ack only
    set_data(3, 8'h91); req_i = 4'b1000; last_i = 4'b1000;
    tick();
    check("fe_last_grant", 32'(grant_o), 32'h8);
    exp_q.push_back({4'b0000, 4'b1000, 8'h91});
    tx_ack_i = 1'b1; frame_end_i = 1'b1;
    tick();
    tx_ack_i = 1'b0; frame_end_i = 1'b0; req_i = '0; last_i = '0;
    check("fe_last_idle", 32'(busy_o), 32'h0);

    // Frame end with ack on non-last word: ack and abort together
    set_data(1, 8'hA1); req_i = 4'b0010;
    tick();
    check("fe_mid_grant", 32'(grant_o), 32'h2);
    exp_q.push_back({4'b0010, 4'b0010, 8'hA1});
    tx_ack_i = 1'b1; frame_end_i = 1'b1;
    tick();
    tx_ack_i = 1'b0; frame_end_i = 1'b0; req_i = '0;
    check("fe_mid_idle", 32'(busy_o), 32'h0);

    // Reset mid-burst, then requester 0 wins first
    set_data(3, 8'hB3); req_i = 4'b1000;
    tick();
    check("rstm_grant", 32'(grant_o), 32'h8);
    rst = 1'b1;
    #1;
    check("rstm_outputs", 32'({grant_o, tx_req_o, tx_data_o, busy_o, ack_o, abort_o}), 32'h0);
    tick();
    rst = 1'b0;
    set_data(0, 8'hB0); req_i = 4'b1001; last_i = 4'b1001;
    tick();
    check("rstm_first_winner", 32'(grant_o), 32'h1);
    ack_word(0, 8'hB0);
    req_i = '0; last_i = '0;

    repeat (3) tick();
    check("queue_drain", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
